// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_CHECK_EN: zero divisor finishes on the capture edge.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef DIV_ZERO_CHECK_EN
    logic             dbz_q, dbz_d;
`endif

    // Partial remainder never exceeds the divisor, so A fits in WIDTH bits
    // between steps; only the shifted trial value needs the extra bit.
    logic [WIDTH:0]   sa;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] q_nx;

    assign sa   = {a_q, q_q[WIDTH-1]};
    assign t    = sa - {1'b0, m_q};
    assign a_nx = t[WIDTH] ? sa[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_nx = {q_q[WIDTH-2:0], ~t[WIDTH]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = done_q;
        busy_d  = busy_q;
`ifdef DIV_ZERO_CHECK_EN
        dbz_d   = dbz_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
`endif
                        a_d     = '0;
                        q_d     = dividend;
                        m_d     = divisor;
                        cnt_d   = CW'(WIDTH);
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = S_CALC;
`ifdef DIV_ZERO_CHECK_EN
                    end
`endif
                end
            end
            S_CALC: begin
                a_d   = a_nx;
                q_d   = q_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = q_nx;
                    rem_d   = a_nx;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Require start low for a cycle before re-arming.
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign done      = done_q;
    assign busy      = busy_q;
`ifdef DIV_ZERO_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against an arithmetic model.
// Honours DIV_ZERO_CHECK_EN the same way the design does.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, zero divisor gives all ones / dividend.
    function automatic void model(input int dd, input int dv,
                                  output int q, output int r);
        if (dv == 0) begin
            q = (1 << W) - 1;
            r = dd;
        end else begin
            q = dd / dv;
            r = dd % dv;
        end
    endfunction

    function automatic bit fast_zero(input int dv);
`ifdef DIV_ZERO_CHECK_EN
        return dv == 0;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one operation; returns with DUT in DONE (hold) or back in IDLE.
    task automatic run_op(input int dd, input int dv,
                          input bit hold, input bit scramble);
        int q, r, edges, lat;
        model(dd, dv, q, r);
        lat = fast_zero(dv) ? 1 : W + 1;
        @(negedge clk);
        dividend = W'(dd);
        divisor  = W'(dv);
        start    = 1'b1;
        @(posedge clk);
        #1;
        edges = 1;
        if (!fast_zero(dv)) begin
            chk("cap_done_low", done, 0);
            chk("cap_busy_high", busy, 1);
        end
        while (!done && edges < 3 * W) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (scramble) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
            if (!done && busy !== 1'b1) chk("calc_busy", busy, 1);
        end
        chk("latency", edges, lat);
        chk("done", done, 1);
        chk("busy_after", busy, 0);
        chk("quotient", quotient, q);
        chk("remainder", remainder, r);
        chk("dbz", div_by_zero, fast_zero(dv) ? 1 : 0);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #1;
            chk("idle_done_held", done, 1);
            chk("idle_q_held", quotient, q);
        end
    endtask

    initial begin
        int q, r, dd, dv;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op(250, 13, 0, 0);
        run_op(255, 255, 0, 0);
        run_op(7, 250, 0, 0);
        run_op(255, 1, 0, 0);
        run_op(100, 0, 0, 0);

        // Asynchronous reset between edges 4 and 5 of an operation.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_done", done, 0);
        chk("arst_busy", busy, 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op(200, 7, 0, 0);

        // start held through DONE: no recapture, results stable.
        run_op(50, 6, 1, 0);
        model(50, 6, q, r);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(posedge clk);
            #1;
            if (i % 5 == 4) begin
                chk("hold_done", done, 1);
                chk("hold_busy", busy, 0);
                chk("hold_q", quotient, q);
                chk("hold_r", remainder, r);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        run_op(14, 3, 0, 0);

        run_op(99, 10, 0, 1);

        for (int i = 0; i < 24; i++) begin
            dd = int'($urandom_range(0, 255));
            dv = (i % 8 == 3) ? 0 : int'($urandom_range(0, 255));
            run_op(dd, dv, 0, i % 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake. Datapath companion to the shift-add multiplier in the Booth Multiplier area; it performs the inverse operation for the MIPS DIVU path. It latches operands on start, iterates WIDTH cycles and holds quotient/remainder until the next operation.

## Interface
- WIDTH, 8: operand, quotient and remainder width in bits (≥2).
- clk  input  1  rising-edge clock; only clock of the block.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; sampled on the capture edge.
- divisor  input  WIDTH  unsigned divisor; sampled on the capture edge.
- quotient  output  WIDTH  registered result; reset 0.
- remainder  output  WIDTH  registered result; reset 0.
- done  output  1  result valid; reset 0.
- busy  output  1  high in CALC; reset 0.
- div_by_zero  output  1  divide-by-zero flag; reset 0 (see Configuration).

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE and clears all outputs and internal registers, regardless of clock.
- IDLE, start=1: capture edge. Load A (WIDTH+1 bits) = 0, Q = dividend, M = divisor, counter = WIDTH. Clear done and div_by_zero, set busy, go to CALC.
- IDLE, start=0: hold. quotient/remainder keep last result.
- CALC, per edge: shift {A,Q} left 1. T = A − {0,M} in WIDTH+1 bits. If T's MSB is 0, A = T and Q[0] = 1. Otherwise A is unchanged and Q[0] = 0. Decrement counter.
- CALC, edge where counter goes 1→0: quotient = Q (after this edge's update), remainder = A[WIDTH−1:0], done = 1, busy = 0, go to DONE.
- DONE: outputs held, done=1. start=0 leads to IDLE on the next edge, with done staying 1 until the next capture edge. start=1 keeps DONE; no restart until start has been low at least one cycle.
- start in CALC is ignored. Operand changes after the capture edge are ignored.
- Arithmetic: unsigned only. quotient = floor(dividend/divisor). remainder = dividend mod divisor. Divisor 0 with no special handling yields quotient = all ones and remainder = dividend.

## Timing
- Capture edge = edge 1. CALC runs on edges 2..WIDTH+1.
- done and results are registered at edge WIDTH+1, which is edge 9 for WIDTH=8.
- busy is high from edge 1 through edge WIDTH+1, exclusive of the final edge.
- Minimum op-to-op spacing: WIDTH+3 edges (DONE → IDLE needs start low for one edge, then a new capture edge).
- Reset asserted mid-CALC: immediate return to IDLE, done=0, busy=0, results cleared. After reset is released, the next start behaves normally.
- Reset release coincident with a clock edge: that edge is ignored. Capture occurs on the first edge with reset high and start high.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - A capture edge with divisor==0 goes directly IDLE → DONE.
  - quotient = all ones, remainder = dividend, div_by_zero = 1, done = 1 at edge 1.
  - busy never asserts for that operation.
  - div_by_zero clears at the next capture edge.
- DIV_ZERO_CHECK_EN undefined:
  - div_by_zero is tied 0.
  - Divisor 0 runs the full WIDTH iterations and gives quotient all ones and remainder = dividend at edge WIDTH+1.

## Test plan
- WIDTH=8, dividend=250, divisor=13, start pulse → done at edge 9, quotient=19, remainder=3, busy low after.
- Back-to-back operations 255/255, then 7/250, then 255/1 → (1,0), (0,7), (255,0). done drops on each capture edge.
- Divisor=0, dividend=100: with DIV_ZERO_CHECK_EN, done and div_by_zero at edge 1 with (255,100). Without it, done at edge 9 with (255,100) and div_by_zero=0.
- 200/7 started, reset pulled low between edges 4 and 5 → done, busy, quotient and remainder all 0 asynchronously. Then 200/7 again → (28,4) at edge 9.
- start held high through DONE for 20 cycles → no new capture, done stays 1, results stable. Then drop start and raise it with 14/3 → (4,2).
- Change dividend/divisor on every cycle during CALC of 99/10 → result (9,9) unaffected.
